// File: rtl/booth2_mul_pkg.sv
// Shared Booth-2 multiplier definitions: row geometry, row alignment, the
// sign-extension correction constant and CSA-tree sizing helpers.
package booth2_mul_pkg;

    // Bits of multiplier examined per Booth-2 digit.
    localparam int unsigned BOOTH2_TRA_WD = 3;

    // Widest product the constant helpers below are sized for.
    localparam int unsigned MAX_PROD_WD = 128;

    function automatic int unsigned pp_num(input int unsigned mul_in_wd);
        return mul_in_wd / 2;
    endfunction

    function automatic int unsigned pp_wd(input int unsigned mul_in_wd);
        return mul_in_wd + 1;
    endfunction

    function automatic int unsigned prod_wd(input int unsigned mul_in_wd);
        return 2 * mul_in_wd;
    endfunction

    // Row i carries weight 4^i, i.e. a left shift of 2i bit positions.
    function automatic int unsigned row_shift(input int unsigned row_idx);
        return 2 * row_idx;
    endfunction

    // Each row is zero-extended with ei (= ~msb) placed just above its MSB.
    // sign_extend(row) = row + ei*2^PP_WD - 2^PP_WD, so the rows need a single
    // constant of -sum(2^(PP_WD+2i)) to become exact. Returned mod 2^MAX_PROD_WD;
    // callers keep the low PROD_WD bits.
    function automatic logic [MAX_PROD_WD-1:0] sext_corr(input int unsigned mul_in_wd);
        logic [MAX_PROD_WD-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < pp_num(mul_in_wd); i++) begin
            k = k - (MAX_PROD_WD'(1) << (pp_wd(mul_in_wd) + row_shift(i)));
        end
        return k;
    endfunction

    // Rows left after the first level: 4:2 groups, a trailing 3:2 for three
    // leftover rows, otherwise leftovers pass straight through.
    function automatic int unsigned l1_rows(input int unsigned n);
        int unsigned rem;
        rem = n % 4;
        return 2 * (n / 4) + ((rem == 3) ? 2 : rem);
    endfunction

    // One 3:2 level: every full group of three rows becomes two.
    function automatic int unsigned csa_next(input int unsigned n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Rows present at the input of tree level lvl.
    function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
        int unsigned r;
        r = n;
        for (int unsigned l = 0; l < lvl; l++) begin
            r = csa_next(r);
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int unsigned csa_levels(input int unsigned n);
        int unsigned r;
        int unsigned l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = csa_next(r);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/booth2_mul_csa_3to2.sv
// Row of full adders: three addends in, sum row and left-aligned carry row out.
// The carry row is already shifted by one; the carry out of the MSB is dropped
// because all arithmetic here is modulo 2^WD.
module booth2_mul_csa_3to2 #(
    parameter int unsigned WD = 8
) (
    input  logic [WD-1:0] a,
    input  logic [WD-1:0] b,
    input  logic [WD-1:0] c,
    output logic [WD-1:0] sum,
    output logic [WD-1:0] carry
);

    // Bitwise full-adder: parity to sum, majority to the next column's carry.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = {(a[WD-2:0] & b[WD-2:0]) | (a[WD-2:0] & c[WD-2:0]) | (b[WD-2:0] & c[WD-2:0]),
                 1'b0};
    end

endmodule

// File: rtl/booth2_mul_pp_compressor.sv
// Booth-2 partial-product compressor: aligns the PP_NUM rows, reduces them with
// a 4:2 first level followed by a 3:2 tree to two rows, registers those, then
// resolves them with a carry-propagate adder into the signed product.
// Optional build macro BOOTH2_MUL_COMP_MID_REG_EN adds a register stage after
// the first tree level (latency 3 instead of 2, same results).
module booth2_mul_pp_compressor
    import booth2_mul_pkg::*;
#(
    parameter int unsigned MUL_IN_WD = 32,
    localparam int unsigned PP_NUM = pp_num(MUL_IN_WD),
    localparam int unsigned PP_WD = pp_wd(MUL_IN_WD),
    localparam int unsigned PROD_WD = prod_wd(MUL_IN_WD)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    val_i,
    input  logic [PP_NUM*PP_WD-1:0] ppi,
    input  logic [PP_NUM-1:0]       si,
    input  logic [PP_NUM-1:0]       ei,
    output logic                    val_o,
    output logic [PROD_WD-1:0]      prod_o
);

    localparam int unsigned L1_GRP = PP_NUM / 4;
    localparam int unsigned L1_REM = PP_NUM % 4;
    localparam int unsigned L1_ROWS = l1_rows(PP_NUM);
    // First-level rows plus the si row and the correction constant row.
    localparam int unsigned TREE_IN = L1_ROWS + 2;
    localparam int unsigned NUM_LVL = csa_levels(TREE_IN);
    localparam logic [MAX_PROD_WD-1:0] CORR_FULL = sext_corr(MUL_IN_WD);
    localparam logic [PROD_WD-1:0] CORR = CORR_FULL[PROD_WD-1:0];

    // ------------------------------------------------------------------
    // Row alignment
    // ------------------------------------------------------------------
    logic [PROD_WD-1:0] pp_row [PP_NUM];
    logic [PROD_WD-1:0] si_row;

    for (genvar i = 0; i < PP_NUM; i++) begin : g_row
        assign pp_row[i] = PROD_WD'({ei[i], ppi[i*PP_WD +: PP_WD]}) << row_shift(i);
    end

    // si bits land on the even columns 2i; every other column is zero.
    for (genvar bt = 0; bt < PROD_WD; bt++) begin : g_si_bit
        if ((bt % 2 == 0) && (bt / 2 < PP_NUM)) begin : g_set
            assign si_row[bt] = si[bt/2];
        end else begin : g_zero
            assign si_row[bt] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // First tree level: PP_NUM rows down to L1_ROWS rows
    // ------------------------------------------------------------------
    logic [PROD_WD-1:0] l1 [L1_ROWS];

    for (genvar g = 0; g < L1_GRP; g++) begin : g_l1_4to2
        logic [PROD_WD-1:0] s1;
        logic [PROD_WD-1:0] c1;

        booth2_mul_csa_3to2 #(
            .WD(PROD_WD)
        ) u_csa_a (
            .a    (pp_row[4*g]),
            .b    (pp_row[4*g+1]),
            .c    (pp_row[4*g+2]),
            .sum  (s1),
            .carry(c1)
        );

        booth2_mul_csa_3to2 #(
            .WD(PROD_WD)
        ) u_csa_b (
            .a    (s1),
            .b    (c1),
            .c    (pp_row[4*g+3]),
            .sum  (l1[2*g]),
            .carry(l1[2*g+1])
        );
    end

    if (L1_REM == 3) begin : g_l1_rem3
        booth2_mul_csa_3to2 #(
            .WD(PROD_WD)
        ) u_csa_rem (
            .a    (pp_row[4*L1_GRP]),
            .b    (pp_row[4*L1_GRP+1]),
            .c    (pp_row[4*L1_GRP+2]),
            .sum  (l1[2*L1_GRP]),
            .carry(l1[2*L1_GRP+1])
        );
    end else begin : g_l1_pass
        for (genvar r = 0; r < L1_REM; r++) begin : g_rem
            assign l1[2*L1_GRP+r] = pp_row[4*L1_GRP+r];
        end
    end

    // ------------------------------------------------------------------
    // Optional mid-tree register
    // ------------------------------------------------------------------
    logic [PROD_WD-1:0] t_rows [L1_ROWS];
    logic [PROD_WD-1:0] t_si;
    logic               t_val;

`ifdef BOOTH2_MUL_COMP_MID_REG_EN
    logic               vm_q;
    logic [PROD_WD-1:0] l1_q [L1_ROWS];
    logic [PROD_WD-1:0] si_q;

    // Mid stage: capture first-level rows on a valid beat, hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vm_q <= 1'b0;
            si_q <= '0;
            for (int j = 0; j < L1_ROWS; j++) begin
                l1_q[j] <= '0;
            end
        end else begin
            vm_q <= val_i;
            if (val_i) begin
                l1_q <= l1;
                si_q <= si_row;
            end
        end
    end

    assign t_rows = l1_q;
    assign t_si   = si_q;
    assign t_val  = vm_q;
`else
    assign t_rows = l1;
    assign t_si   = si_row;
    assign t_val  = val_i;
`endif

    // ------------------------------------------------------------------
    // Remaining 3:2 tree: TREE_IN rows down to two
    // ------------------------------------------------------------------
    logic [PROD_WD-1:0] lvl0 [TREE_IN];

    for (genvar j = 0; j < L1_ROWS; j++) begin : g_lvl0
        assign lvl0[j] = t_rows[j];
    end
    assign lvl0[L1_ROWS]   = t_si;
    assign lvl0[L1_ROWS+1] = CORR;

    for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
        localparam int unsigned N_IN = csa_rows(TREE_IN, k);
        localparam int unsigned N_GRP = N_IN / 3;
        localparam int unsigned N_OUT = csa_next(N_IN);

        logic [PROD_WD-1:0] rin [N_IN];
        logic [PROD_WD-1:0] rout [N_OUT];

        if (k == 0) begin : g_src0
            assign rin = lvl0;
        end else begin : g_srcn
            assign rin = g_lvl[k-1].rout;
        end

        for (genvar g = 0; g < N_GRP; g++) begin : g_csa
            booth2_mul_csa_3to2 #(
                .WD(PROD_WD)
            ) u_csa (
                .a    (rin[3*g]),
                .b    (rin[3*g+1]),
                .c    (rin[3*g+2]),
                .sum  (rout[2*g]),
                .carry(rout[2*g+1])
            );
        end

        for (genvar r = 0; r < N_IN % 3; r++) begin : g_pass
            assign rout[2*N_GRP+r] = rin[3*N_GRP+r];
        end
    end

    logic [PROD_WD-1:0] tree_s;
    logic [PROD_WD-1:0] tree_c;

    assign tree_s = g_lvl[NUM_LVL-1].rout[0];
    assign tree_c = g_lvl[NUM_LVL-1].rout[1];

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic               v1_q;
    logic [PROD_WD-1:0] s_q;
    logic [PROD_WD-1:0] c_q;
    logic               val_q;
    logic [PROD_WD-1:0] prod_q;

    // Stage 1: register the redundant sum/carry pair on a valid beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q <= 1'b0;
            s_q  <= '0;
            c_q  <= '0;
        end else begin
            v1_q <= t_val;
            if (t_val) begin
                s_q <= tree_s;
                c_q <= tree_c;
            end
        end
    end

    // Stage 2: carry-propagate add; carry out of the MSB is discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            val_q  <= 1'b0;
            prod_q <= '0;
        end else begin
            val_q <= v1_q;
            if (v1_q) begin
                prod_q <= s_q + c_q;
            end
        end
    end

    assign val_o  = val_q;
    assign prod_o = prod_q;

endmodule

// File: tb/tb_booth2_mul_pp_compressor.sv
// Bench for booth2_mul_pp_compressor: a Booth-2 row generator feeds the DUT,
// a signed-multiply scoreboard checks every result, its cycle and order, and
// that prod_o holds between results; directed vectors carry literal answers.
module tb_booth2_mul_pp_compressor;

    localparam int W   = 32;
    localparam int PPN = 16;
    localparam int PPW = 33;
    localparam int PW  = 64;
`ifdef BOOTH2_MUL_COMP_MID_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk;
    logic               rstn;
    logic               val_i;
    logic [PPN*PPW-1:0] ppi;
    logic [PPN-1:0]     si;
    logic [PPN-1:0]     ei;
    logic               val_o;
    logic [PW-1:0]      prod_o;

    booth2_mul_pp_compressor #(
        .MUL_IN_WD(W)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .val_i (val_i),
        .ppi   (ppi),
        .si    (si),
        .ei    (ei),
        .val_o (val_o),
        .prod_o(prod_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PW-1:0] exp;
        int            due;
    } ent_t;

    ent_t          sb[$];
    logic [PW-1:0] last_prod = '0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Booth-2 recoding of b, rows are multiples of a; negatives inverted + si.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]            bx;
        logic [2:0]            trip;
        logic signed [PPW-1:0] as33;
        logic signed [PPW-1:0] row;
        int                    d;
        bx   = {b, 1'b0};
        as33 = $signed({a[W-1], a});
        for (int i = 0; i < PPN; i++) begin
            trip = bx[2*i+2 -: 3];
            d = int'(trip[1]) + int'(trip[0]) - 2 * int'(trip[2]);
            case ((d < 0) ? -d : d)
                0:       row = '0;
                1:       row = as33;
                default: row = as33 <<< 1;
            endcase
            if (d < 0) row = ~row;
            ppi[i*PPW +: PPW] = row;
            si[i] = (d < 0);
            ei[i] = ~row[PPW-1];
        end
        val_i = 1'b1;
    endtask

    // Caller sits just after a rising edge; one operand set is applied for one cycle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb_;
        ent_t   e;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        drive_op(a, b);
        e.exp = sa * sb_;
        e.due = cyc + LAT;
        sb.push_back(e);
        tick();
        val_i = 1'b0;
        for (int i = 0; i < PPN; i++) ppi[i*PPW +: 32] = $urandom;
        si = 16'($urandom);
        ei = 16'($urandom);
    endtask

    task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [PW-1:0] lit, input string name);
        int n;
        issue(a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!val_o && n < 10);
        check({name, "_valid"}, {63'd0, val_o}, 64'd1);
        check(name, prod_o, lit);
        tick();
    endtask

    // Scoreboard compare, sampled on the falling edge.
    always @(negedge clk) begin
        ent_t e;
        if (!rstn) begin
            check("rst_val_o", {63'd0, val_o}, 64'd0);
            check("rst_prod_o", prod_o, 64'd0);
            last_prod = '0;
        end else if (val_o) begin
            if (sb.size() == 0) begin
                check("spurious_val_o", {63'd0, val_o}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.due));
                check("prod", prod_o, e.exp);
            end
            last_prod = prod_o;
        end else begin
            check("hold", prod_o, last_prod);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("missing_val_o", {63'd0, val_o}, 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rstn  = 1'b0;
        val_i = 1'b0;
        ppi   = '0;
        si    = '0;
        ei    = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        run_single(32'd3, 32'd5, 64'h0000_0000_0000_000F, "p3x5");
        run_single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1xm1");
        run_single(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min");
        run_single(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "max_x_min");
        run_single(32'd0, 32'h1234_5678, 64'h0, "zero_x");

        // Back-to-back random operands.
        for (int i = 0; i < 1000; i++) issue($urandom, $urandom);
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();

        // Reset while an operation is in flight: no late val_o afterwards.
        issue(32'd1234, 32'd5678);
        rstn = 1'b0;
        sb.delete();
        tick();
        rstn = 1'b1;
        repeat (LAT + 2) tick();
        run_single(32'd6, 32'd7, 64'd42, "after_rst");

        // Gaps: result must hold unchanged while idle.
        run_single(32'hFFFF_FFF9, 32'd9, 64'hFFFF_FFFF_FFFF_FFC1, "m7x9");
        repeat (3) tick();
        check("m7x9_held", prod_o, 64'hFFFF_FFFF_FFFF_FFC1);
        run_single(32'd9, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFC1, "9xm7");
        repeat (3) tick();
        check("9xm7_held", prod_o, 64'hFFFF_FFFF_FFFF_FFC1);

        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
